fft_frame_counter: RTL

FFT_FRAME_COUNTER -- requirements
Module: fft_frame_counter

---
 rtl/fft_frame_counter.sv | 81 ++++++++
 1 files changed

// File: rtl/fft_frame_counter.sv
// fft_frame_counter: in-frame sample counter and frame index tracker for FFT streaming, state updates on the falling clock edge
// Ports: i_clk (falling-edge clock), i_rst_n (async active-low reset), i_valid (arm request),
//        i_oneshot (single frame mode, latched on arm), i_stop (disarm), i_sync (frame realign),
//        o_fft_cnt (sample position), o_frame_idx (frames completed), o_busy (running),
//        o_frame_start / o_frame_end (frame boundary strobes), o_sync_err (sticky misaligned sync).
// Optional feature: define FFT_CNT_SYNC_CHECK_EN to add o_sync_err and its checking logic.
module fft_frame_counter #(
  parameter int CNT_W   = 10,
  parameter int FFT_LEN = 1024,
  parameter int FRM_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_oneshot,
  input  logic             i_stop,
  input  logic             i_sync,
  output logic [CNT_W-1:0] o_fft_cnt,
  output logic [FRM_W-1:0] o_frame_idx,
  output logic             o_busy,
  output logic             o_frame_start,
`ifdef FFT_CNT_SYNC_CHECK_EN
  output logic             o_sync_err,
`endif
  output logic             o_frame_end
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [FRM_W-1:0] r_idx;
  logic             r_busy;
  logic             r_oneshot;
  logic             w_last;
  assign w_last        = r_cnt == CNT_W'(FFT_LEN - 1);
  assign o_fft_cnt     = r_cnt;
  assign o_frame_idx   = r_idx;
  assign o_busy        = r_busy;
  assign o_frame_start = r_busy && r_cnt == '0;
  assign o_frame_end   = r_busy && w_last;
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_oneshot <= 1'b0;
    end else if (r_state == IDLE) begin
      if (i_valid) begin
        r_state   <= RUN;
        r_cnt     <= '0;
        r_idx     <= '0;
        r_busy    <= 1'b1;
        r_oneshot <= i_oneshot;
      end
    end else if (i_stop) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      // sync and the natural wrap both restart the frame; a frame only completes when the last sample was reached
      r_cnt <= (i_sync || w_last) ? '0 : r_cnt + CNT_W'(1);
      r_idx <= r_idx + FRM_W'(w_last);
      if (w_last && r_oneshot) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end
    end
  end
`ifdef FFT_CNT_SYNC_CHECK_EN
  logic r_sync_err;
  assign o_sync_err = r_sync_err;
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_sync_err <= 1'b0;
    else if (r_state == IDLE)
      r_sync_err <= i_valid ? 1'b0 : r_sync_err;
    else if (!i_stop && i_sync && r_cnt != '0 && !w_last)
      r_sync_err <= 1'b1;
  end
`endif
endmodule
